detector_jogada: RTL and testbench
==================================

// Module: detector_jogada
// PURPOSE
//   Input stage of the memory game, directly upstream of circuito_exp7's game datapath.
//   - Synchronises the four raw player buttons and filters bounce.
//   - Validates that exactly one button is pressed.
//   - Emits one single-cycle jogada_feita strobe per press, with the 4-bit one-hot code held on jogada.
//   - Requires release before the next press is accepted.
// PARAMETERS
//   ESTAVEL  2  press is accepted after ESTAVEL+1 consecutive equal synchronised samples;
//               release needs ESTAVEL consecutive zero samples; legal range 1..15
// PORTS
//   clock            in   1  system clock; all flops on rising edge
//   reset            in   1  asynchronous, active-low reset
//   habilita         in   1  1 = presses may be accepted (driven by the game's vez_jogador)
//   botoes           in   4  raw buttons, active-high, asynchronous to clock
//   jogada           out  4  last valid one-hot code; held until the next valid press
//   jogada_feita     out  1  1-cycle strobe: a valid one-hot press was accepted
//   jogada_multipla  out  1  1-cycle strobe: a stable press had 0 or >=2 buttons set
//   ocupado          out  1  1 whenever the FSM is not in ESPERA
//   db_estado        out  3  current FSM state code, for the 7-seg debug display
// BEHAVIOUR
//   Reset (reset=0, async):
//     - jogada=0000, jogada_feita=0, jogada_multipla=0, ocupado=0, db_estado=000.
//     - Synchroniser flops, amostra and cnt are cleared.
//     - This holds mid-operation: a strobe in flight is killed immediately.
//   Synchroniser: 2 flops per bit. botoes_s is the second stage. The FSM sees only botoes_s.
//   Registers:
//     - amostra[3:0]: the candidate code.
//     - cnt: $clog2(ESTAVEL+1) bits, saturating, never wraps.
//   All outputs are registered/Moore. No combinational path from botoes to any output.
//   FSM (state codes):
//     ESPERA 000
//       - botoes_s!=0 and habilita=1: amostra<=botoes_s, cnt<=0, go to FILTRA.
//       - otherwise: stay.
//     FILTRA 001
//       - habilita=0: go to ESPERA, no strobe.
//       - botoes_s==0: go to ESPERA (glitch).
//       - botoes_s!=amostra and !=0: amostra<=botoes_s, cnt<=0 (bounce restart).
//       - botoes_s==amostra and cnt==ESTAVEL-1: go to EMITE.
//       - botoes_s==amostra, cnt<ESTAVEL-1: cnt<=cnt+1.
//     EMITE 010 (exactly one cycle, then go to SOLTA with cnt<=0)
//       - amostra one-hot: jogada<=amostra, asserted together with jogada_feita=1.
//       - else: jogada_multipla=1, jogada unchanged.
//     SOLTA 011
//       - botoes_s!=0: cnt<=0.
//       - botoes_s==0: cnt<=cnt+1.
//       - cnt==ESTAVEL-1 and botoes_s==0: go to ESPERA.
//       - habilita is ignored here.
//   Latency: the first edge that samples botoes high is edge k.
//     - A press held through edges k..k+ESTAVEL gives jogada_feita high from edge k+ESTAVEL+2
//       to edge k+ESTAVEL+3. With the default, k+4..k+5.
//     - A minimum 3-cycle press is accepted with ESTAVEL=2.
//   Boundaries:
//     - Press shorter than ESTAVEL+1 samples: no strobe.
//     - Held press of any length: exactly one strobe.
//     - New press during SOLTA: ignored, and the release counter restarts.
//     - jogada_feita and jogada_multipla are never high together.
//     - habilita rising while a button is already held: accepted after full filtering from ESPERA.
// TESTING
//   T1 reset=0 at any time, including within FILTRA/EMITE
//      -> all outputs 0 within the same cycle, db_estado=000.
//   T2 habilita=1, botoes=0100 for 3 cycles from edge k
//      -> jogada_feita=1 only in cycle k+4..k+5, jogada=0100 held afterwards, ocupado back to 0 after release.
//   T3 botoes=0010 for 2 cycles only; also 0100,0000(1 cycle),0100
//      -> no strobe on the glitch; the bounce sequence yields one strobe, timed from the second rising edge.
//   T4 botoes=0011 held 5 cycles, with previous jogada=0100
//      -> jogada_multipla 1-cycle pulse, jogada_feita=0, jogada stays 0100.
//   T5 botoes=1000 held 40 cycles, then 0001 after only 1 zero cycle, then 0001 after 2 zero cycles
//      -> single 1000 strobe; the first 0001 press is ignored; the second 0001 press gives one strobe.
//   T6 habilita=0 with botoes=0001 for 10 cycles; then habilita dropped in FILTRA
//      -> no strobes, db_estado returns to 000.

Source files
------------

// File: rtl/detector_jogada.sv
// Player-move input stage: synchronises and debounces four buttons, then emits one
// strobe per accepted press. The next press is accepted only after the buttons are released.
module detector_jogada #(
   parameter int ESTAVEL = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] botoes,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       jogada_multipla,
   output logic       ocupado,
   output logic [2:0] db_estado
);

   localparam int CW = $clog2(ESTAVEL + 1);
   localparam logic [CW-1:0] CNT_FIM = CW'(ESTAVEL - 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic [2:0] {
      ESPERA = 3'b000,
      FILTRA = 3'b001,
      EMITE  = 3'b010,
      SOLTA  = 3'b011
   } estado_t;

   estado_t        estado;
   logic [3:0]     botoes_m;
   logic [3:0]     botoes_s;
   logic [3:0]     amostra;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_inc;
   logic           um_quente;

   // Two-flop synchroniser; only botoes_s is visible to the FSM.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         botoes_m <= 4'b0000;
         botoes_s <= 4'b0000;
      end else begin
         botoes_m <= botoes;
         botoes_s <= botoes_m;
      end
   end

   assign um_quente = (amostra != 4'b0000) && ((amostra & (amostra - 4'd1)) == 4'b0000);
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign db_estado = estado;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado          <= ESPERA;
         amostra         <= 4'b0000;
         cnt             <= '0;
         jogada          <= 4'b0000;
         jogada_feita    <= 1'b0;
         jogada_multipla <= 1'b0;
         ocupado         <= 1'b0;
      end else begin
         jogada_feita    <= 1'b0;
         jogada_multipla <= 1'b0;
         case (estado)
            ESPERA: begin
               if (botoes_s != 4'b0000 && habilita) begin
                  amostra <= botoes_s;
                  cnt     <= '0;
                  estado  <= FILTRA;
                  ocupado <= 1'b1;
               end
            end
            FILTRA: begin
               if (!habilita || botoes_s == 4'b0000) begin
                  estado  <= ESPERA;
                  ocupado <= 1'b0;
               end else if (botoes_s != amostra) begin
                  amostra <= botoes_s;
                  cnt     <= '0;
               end else if (cnt == CNT_FIM) begin
                  // Strobes are raised on entry so they are high for exactly the EMITE cycle.
                  estado <= EMITE;
                  if (um_quente) begin
                     jogada       <= amostra;
                     jogada_feita <= 1'b1;
                  end else begin
                     jogada_multipla <= 1'b1;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            EMITE: begin
               estado <= SOLTA;
               cnt    <= '0;
            end
            SOLTA: begin
               if (botoes_s != 4'b0000) begin
                  cnt <= '0;
               end else if (cnt == CNT_FIM) begin
                  estado  <= ESPERA;
                  ocupado <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               estado  <= ESPERA;
               ocupado <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios plus random button traffic, each cycle
// compared against a run-length model of the press/release rules.
module tb_detector_jogada;

   localparam int ESTAVEL = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       habilita = 1'b0;
   logic [3:0] botoes = 4'b0000;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       jogada_multipla;
   logic       ocupado;
   logic [2:0] db_estado;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   detector_jogada #(.ESTAVEL(ESTAVEL)) dut (
      .clock(clock),
      .reset(reset),
      .habilita(habilita),
      .botoes(botoes),
      .jogada(jogada),
      .jogada_feita(jogada_feita),
      .jogada_multipla(jogada_multipla),
      .ocupado(ocupado),
      .db_estado(db_estado)
   );

   // Reference: run lengths of synchronised samples decide acceptance and release.
   logic [3:0] s1, s2, cand, m_jogada;
   int         run, zeros;
   bit         filt, emit, rel, m_feita, m_mult;

   function automatic void model_reset();
      s1 = 0; s2 = 0; cand = 0; m_jogada = 0;
      run = 0; zeros = 0;
      filt = 0; emit = 0; rel = 0; m_feita = 0; m_mult = 0;
   endfunction

   function automatic void model_step();
      logic [3:0] s;
      s = s2;
      m_feita = 0;
      m_mult = 0;
      if (emit) begin
         emit = 0; rel = 1; zeros = 0;
      end else if (rel) begin
         zeros = (s == 0) ? zeros + 1 : 0;
         if (zeros >= ESTAVEL) rel = 0;
      end else if (filt) begin
         if (!habilita || s == 0) filt = 0;
         else begin
            if (s != cand) begin cand = s; run = 1; end
            else run = run + 1;
            if (run == ESTAVEL + 1) begin
               filt = 0; emit = 1;
               if ($countones(cand) == 1) begin m_jogada = cand; m_feita = 1; end
               else m_mult = 1;
            end
         end
      end else if (habilita && s != 0) begin
         filt = 1; cand = s; run = 1;
      end
      s2 = s1;
      s1 = botoes;
   endfunction

   function automatic logic [9:0] model_vec();
      logic [2:0] code;
      code = filt ? 3'd1 : emit ? 3'd2 : rel ? 3'd3 : 3'd0;
      return {m_jogada, m_feita, m_mult, (filt | emit | rel), code};
   endfunction

   function automatic logic [9:0] dut_vec();
      return {jogada, jogada_feita, jogada_multipla, ocupado, db_estado};
   endfunction

   task automatic cyc(input logic [3:0] b, input logic h);
      botoes = b;
      habilita = h;
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (dut_vec() !== 10'd0) begin
         errors++; $display("FAIL reset_power got %b expected %b", dut_vec(), 10'd0);
      end
      @(negedge clock) reset = 1'b1;
      for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b1);
      checks++;
      if (db_estado !== 3'b001) begin
         errors++; $display("FAIL reset_pre_filtra got %b expected 001", db_estado);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 10'd0) begin
         errors++; $display("FAIL reset_in_filtra got %b expected %b", dut_vec(), 10'd0);
      end
      model_reset();
      botoes = 4'b0000;
      @(negedge clock) reset = 1'b1;
      for (int i = 0; i < 5; i++) cyc(4'b0100, 1'b1);
      checks++;
      if (jogada_feita !== 1'b1 || db_estado !== 3'b010) begin
         errors++; $display("FAIL reset_pre_emite got feita=%b st=%b expected feita=1 st=010", jogada_feita, db_estado);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== 10'd0) begin
         errors++; $display("FAIL reset_in_emite got %b expected %b", dut_vec(), 10'd0);
      end
      model_reset();
      botoes = 4'b0000;
      @(negedge clock) reset = 1'b1;
   endtask

   task automatic test_press();
      logic [3:0] seq [11];
      for (int i = 0; i < 11; i++) seq[i] = (i < 3) ? 4'b0100 : 4'b0000;
      for (int i = 0; i < 11; i++) begin
         cyc(seq[i], 1'b1);
         checks++;
         if (dut_vec() !== model_vec() || jogada_feita !== (i == 4)) begin
            errors++;
            $display("FAIL press cycle %0d got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      checks++;
      if (jogada !== 4'b0100 || ocupado !== 1'b0) begin
         errors++; $display("FAIL press_end got jogada=%b ocupado=%b expected 0100 0", jogada, ocupado);
      end
   endtask

   task automatic test_glitch();
      logic [3:0] seq [20];
      int nf = 0;
      for (int i = 0; i < 20; i++) seq[i] = 4'b0000;
      seq[0] = 4'b0010; seq[1] = 4'b0010;
      for (int i = 0; i < 8; i++) begin
         cyc(seq[i], 1'b1);
         checks++;
         if (dut_vec() !== model_vec() || jogada_feita !== 1'b0) begin
            errors++; $display("FAIL glitch cycle %0d got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      seq[0] = 4'b0100; seq[1] = 4'b0000; seq[2] = 4'b0100; seq[3] = 4'b0100; seq[4] = 4'b0100;
      for (int i = 0; i < 12; i++) begin
         cyc(seq[i], 1'b1);
         nf += int'(jogada_feita);
         checks++;
         if (dut_vec() !== model_vec() || jogada_feita !== (i == 6)) begin
            errors++; $display("FAIL bounce cycle %0d got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      checks++;
      if (nf != 1) begin
         errors++; $display("FAIL bounce_count got %0d expected 1", nf);
      end
   endtask

   task automatic test_multipla();
      for (int i = 0; i < 11; i++) begin
         cyc((i < 5) ? 4'b0011 : 4'b0000, 1'b1);
         checks++;
         if (dut_vec() !== model_vec() || jogada_multipla !== (i == 4) ||
             jogada_feita !== 1'b0 || jogada !== 4'b0100) begin
            errors++; $display("FAIL multipla cycle %0d got %b expected %b", i, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_held_release();
      logic [3:0] got [$];
      logic [3:0] seq [$];
      for (int i = 0; i < 40; i++) seq.push_back(4'b1000);
      seq.push_back(4'b0000);
      for (int i = 0; i < 4; i++) seq.push_back(4'b0001);
      seq.push_back(4'b0000); seq.push_back(4'b0000);
      for (int i = 0; i < 4; i++) seq.push_back(4'b0001);
      for (int i = 0; i < 6; i++) seq.push_back(4'b0000);
      foreach (seq[i]) begin
         cyc(seq[i], 1'b1);
         if (jogada_feita) got.push_back(jogada);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL held cycle %0d got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      checks++;
      if (got.size() != 2 || got[0] !== 4'b1000 || got[1] !== 4'b0001) begin
         errors++; $display("FAIL held_strobes got %0d strobes expected 2 (1000 then 0001)", got.size());
      end
   endtask

   task automatic test_habilita();
      int nf = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(4'b0001, 1'b0);
         nf += int'(jogada_feita | jogada_multipla);
         checks++;
         if (dut_vec() !== model_vec() || db_estado !== 3'b000) begin
            errors++; $display("FAIL hab_off cycle %0d got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      for (int i = 0; i < 8; i++) begin
         cyc(4'b0001, (i < 2));
         nf += int'(jogada_feita | jogada_multipla);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL hab_drop cycle %0d got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      checks++;
      if (nf != 0 || db_estado !== 3'b000) begin
         errors++; $display("FAIL hab_drop_end got strobes=%0d st=%b expected 0 000", nf, db_estado);
      end
      for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cyc((i < 10) ? 4'b0010 : 4'b0000, (i >= 4));
         nf += int'(jogada_feita);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL hab_rise cycle %0d got %b expected %b", i, dut_vec(), model_vec());
         end
      end
      checks++;
      if (nf != 1 || jogada !== 4'b0010) begin
         errors++; $display("FAIL hab_rise_end got strobes=%0d jogada=%b expected 1 0010", nf, jogada);
      end
   endtask

   task automatic test_random();
      logic [3:0] b;
      logic       h;
      int         len;
      for (int seg = 0; seg < 300; seg++) begin
         case ($urandom_range(0, 3))
            0: b = 4'b0000;
            1, 2: b = 4'b0001 << $urandom_range(0, 3);
            default: b = 4'($urandom_range(0, 15));
         endcase
         h = ($urandom_range(0, 7) != 0);
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            cyc(b, h);
            checks++;
            if (dut_vec() !== model_vec() || (jogada_feita && jogada_multipla)) begin
               errors++; $display("FAIL random seg %0d cycle %0d got %b expected %b", seg, i, dut_vec(), model_vec());
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_press();
      test_glitch();
      test_multipla();
      test_held_release();
      test_habilita();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
